// File: rtl/mem_accum_pkg.sv
// -----------------------------------------------------------------------------
// mem_accum_pkg
// Shared definitions for the mem_accum capture-and-accumulate block:
//   - state_e   : controller states (LOAD, SUM, DRAIN)
//   - sum_width : result width needed to add CH unsigned DATA_W-bit samples
//   - sat_max   : largest value of a DATA_W-bit sample, used as the clamp
//                 level when the MEM_ACCUM_SAT_EN build option is defined
// No ports (package).
// -----------------------------------------------------------------------------
package mem_accum_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SUM   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // CH samples of at most 2^data_w-1 each need $clog2(ch) extra bits.
    function automatic int sum_width(input int data_w, input int ch);
        return data_w + $clog2(ch);
    endfunction

    function automatic int sat_max(input int data_w);
        return (1 << data_w) - 1;
    endfunction

endpackage

// File: rtl/mem_accum_sp_ram.sv
// -----------------------------------------------------------------------------
// sp_ram
// Single-port RAM with synchronous write and a registered read port. The read
// register only updates when re is high, so it can double as a holding
// register for a stalled output. Only the read register is reset; the array
// contents are left as they are.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-low reset of the read register
//   we     in   write enable (writes wdata at addr)
//   re     in   read enable (loads rdata from addr on the next edge)
//   addr   in   shared read/write address
//   wdata  in   write data
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module sp_ram
    import mem_accum_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_accum.sv
// -----------------------------------------------------------------------------
// mem_accum
// Captures a frame of up to DEPTH multi-channel samples (one RAM per channel),
// sums the channels address by address into a result RAM, then streams the
// result frame out.
//
// Handshakes: a beat transfers on a rising clk edge where valid and ready are
// both high; valid, data and last are held stable by the sender while
// valid is high and ready is low; ready never depends on valid.
//
// Build option: MEM_ACCUM_SAT_EN clamps every sum to 2^DATA_W-1 before it is
// stored (port width unchanged). Undefined: the full SUM_W sum is stored.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted (high only in LOAD)
//   in_data    in   CH samples, channel c at [c*DATA_W +: DATA_W]
//   in_last    in   final beat of the frame
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts result beat
//   out_data   out  channel sum at one address
//   out_last   out  final result beat of the frame
//   busy       out  high in SUM or DRAIN
// -----------------------------------------------------------------------------
module mem_accum
    import mem_accum_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int CH     = 2,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int SUM_W  = sum_width(DATA_W, CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_W-1:0]     out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam logic [1:0]        ST_LOAD   = LOAD;
    localparam logic [1:0]        ST_SUM    = SUM;
    localparam logic [1:0]        ST_DRAIN  = DRAIN;
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   len;        // 1..DEPTH, so one bit wider than an address
    logic [ADDR_W:0]   cnt;        // SUM read index / DRAIN issue index
    logic              pend_valid; // channel RAM outputs hold address pend_addr
    logic [ADDR_W-1:0] pend_addr;

    logic [DATA_W-1:0] ch_q [CH];
    logic [SUM_W-1:0]  sum_full;
    logic [SUM_W-1:0]  sum_store;

    logic              accept;
    logic              close;
    logic              ch_re;
    logic [ADDR_W-1:0] ch_addr;
    logic              res_we;
    logic              res_re;
    logic [ADDR_W-1:0] res_addr;
    logic              drain_adv;
    logic              done;

    assign in_ready  = (state == ST_LOAD);
    assign busy      = (state == ST_SUM) || (state == ST_DRAIN);
    assign accept    = in_valid && in_ready;
    assign close     = accept && (in_last || (wr_addr == LAST_ADDR));

    assign ch_re     = (state == ST_SUM) && (cnt < len);
    assign ch_addr   = (state == ST_LOAD) ? wr_addr : cnt[ADDR_W-1:0];

    // Result writes trail channel reads by one cycle (registered RAM read).
    assign res_we    = (state == ST_SUM) && pend_valid;
    // The result RAM read register is the output register: it only loads
    // when the current beat is absent or leaving.
    assign drain_adv = (state == ST_DRAIN) && (!out_valid || out_ready);
    assign res_re    = drain_adv && (cnt < len);
    assign res_addr  = (state == ST_SUM) ? pend_addr : cnt[ADDR_W-1:0];
    assign done      = out_valid && out_ready && out_last;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        sp_ram #(
            .WIDTH (DATA_W),
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W)
        ) u_ch_ram (
            .clk  (clk),
            .rst  (rst),
            .we   (accept),
            .re   (ch_re),
            .addr (ch_addr),
            .wdata(in_data[c*DATA_W +: DATA_W]),
            .rdata(ch_q[c])
        );
    end

    always_comb begin
        sum_full = '0;
        for (int c = 0; c < CH; c++) begin
            sum_full = sum_full + SUM_W'(ch_q[c]);
        end
    end

`ifdef MEM_ACCUM_SAT_EN
    localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'(sat_max(DATA_W));
    assign sum_store = (sum_full > SAT_MAX) ? SAT_MAX : sum_full;
`else
    assign sum_store = sum_full;
`endif

    sp_ram #(
        .WIDTH (SUM_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_res_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (res_we),
        .re   (res_re),
        .addr (res_addr),
        .wdata(sum_store),
        .rdata(out_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_LOAD;
            wr_addr    <= '0;
            len        <= '0;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            pend_valid <= ch_re;
            pend_addr  <= cnt[ADDR_W-1:0];
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (close) begin
                            len     <= {1'b0, wr_addr} + CNT_ONE;
                            wr_addr <= '0;
                            cnt     <= '0;
                            state   <= ST_SUM;
                        end else begin
                            wr_addr <= wr_addr + ADDR_ONE;
                        end
                    end
                end
                ST_SUM: begin
                    // cnt runs 0..len: len reads plus one cycle for the
                    // trailing result write.
                    if (cnt == len) begin
                        cnt   <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_adv) begin
                        if (res_re) begin
                            out_valid <= 1'b1;
                            out_last  <= ((cnt + CNT_ONE) == len);
                            cnt       <= cnt + CNT_ONE;
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end
                        if (done) begin
                            state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_accum.sv
// -----------------------------------------------------------------------------
// tb_mem_accum
// Self-checking bench for mem_accum with default parameters. Frames are built
// in beats_q; each beat's expected result (plain channel addition, clamped
// when MEM_ACCUM_SAT_EN is defined) is queued in exp_q and compared against
// the streamed output. Inputs are driven and outputs sampled 1 time unit after
// each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_accum;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int CH     = 2;
    localparam int SUM_W  = DATA_W + $clog2(CH);
    localparam int IN_W   = CH * DATA_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SUM_W-1:0] out_data;
    logic             out_last;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_acc_cyc;
    int first_valid_cyc;
    int last_out_cyc;

    logic [IN_W-1:0]  beats_q[$];
    logic [SUM_W-1:0] exp_q[$];

    mem_accum #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CH    (CH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // ---------------- reference model ----------------
    function automatic logic [SUM_W-1:0] ref_sum(input logic [IN_W-1:0] w);
        int s = 0;
        for (int c = 0; c < CH; c++) begin
            s += int'((w >> (c * DATA_W)) & IN_W'((1 << DATA_W) - 1));
        end
`ifdef MEM_ACCUM_SAT_EN
        if (s > (1 << DATA_W) - 1) s = (1 << DATA_W) - 1;
`endif
        return SUM_W'(s);
    endfunction

    // ---------------- drivers ----------------
    // Sends beats_q as one frame; in_last on the final beat if use_last.
    task automatic load_frame(input bit use_last);
        int n = beats_q.size();
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            in_data  = beats_q[i];
            in_last  = use_last && (i == n - 1);
            in_valid = 1'b1;
            while (!in_ready && guard < 4 * DEPTH + 50) begin
                tick();
                guard++;
            end
            if (!in_ready) begin
                n_vec++;
                n_err++;
                $display("FAIL load_timeout: in_ready=%0b required 1 at beat %0d", in_ready, i);
            end
            exp_q.push_back(ref_sum(beats_q[i]));
            last_acc_cyc = cyc + 1;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        beats_q.delete();
    endtask

    // ---------------- scoreboard ----------------
    // mode 0: out_ready high, 1: alternating, 2: random.
    // busy_in: check in_ready stays low until the frame is drained.
    task automatic collect(input int n, input int mode, input bit busy_in);
        int got = 0;
        int guard = 0;
        bit stall = 0;
        logic [SUM_W-1:0] held_d = '0;
        logic held_l = 1'b0;
        logic [SUM_W-1:0] exp;
        first_valid_cyc = -1;
        last_out_cyc = -1;
        while (got < n) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (guard % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (busy_in) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_in_ready: in_ready=%0b required 0", in_ready);
                end
            end
            if (stall) begin
                n_vec++;
                if ({out_valid, out_last, out_data} !== {1'b1, held_l, held_d}) begin
                    n_err++;
                    $display("FAIL hold: valid=%0b last=%0b data=%0d required 1 %0b %0d",
                             out_valid, out_last, out_data, held_l, held_d);
                end
            end
            if (out_valid === 1'b1) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_ready) begin
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    n_vec++;
                    if (out_data !== exp) begin
                        n_err++;
                        $display("FAIL out_data[%0d]: got %0d required %0d", got, out_data, exp);
                    end
                    n_vec++;
                    if (out_last !== (got == n - 1)) begin
                        n_err++;
                        $display("FAIL out_last[%0d]: got %0b required %0b", got, out_last, got == n - 1);
                    end
                    got++;
                    if (got == n) last_out_cyc = cyc + 1;
                    stall = 0;
                end else begin
                    stall  = 1;
                    held_d = out_data;
                    held_l = out_last;
                end
            end else begin
                stall = 0;
            end
            guard++;
            if (guard > 10 * n + 2 * DEPTH + 50) begin
                n_vec++;
                n_err++;
                $display("FAIL collect_timeout: got %0d beats required %0d", got, n);
                break;
            end
            tick();
        end
        out_ready = 1'b0;
        n_vec++;
        if ({in_ready, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL in_ready_return: in_ready=%0b busy=%0b required 1 0", in_ready, busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        n_vec++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b1000 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%0b vld=%0b last=%0b busy=%0b data=%0d required 1 0 0 0 0",
                     in_ready, out_valid, out_last, busy, out_data);
        end
        release_reset();
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < DEPTH; i++) beats_q.push_back({8'(2 * i), 8'(i)});
        load_frame(1'b0);
        collect(DEPTH, 0, 1'b1);
        n_vec++;
        if (first_valid_cyc + 1 - last_acc_cyc != DEPTH + 3) begin
            n_err++;
            $display("FAIL full_first_valid: latency %0d required %0d",
                     first_valid_cyc + 1 - last_acc_cyc, DEPTH + 3);
        end
        n_vec++;
        if (last_out_cyc - last_acc_cyc != 2 * DEPTH + 2) begin
            n_err++;
            $display("FAIL full_out_last_time: %0d required %0d",
                     last_out_cyc - last_acc_cyc, 2 * DEPTH + 2);
        end
    endtask

    task automatic test_short_frame();
        repeat (5) beats_q.push_back(16'hFFFF);
        load_frame(1'b1);
        collect(5, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        int n = $urandom_range(2, DEPTH);
        repeat (n) beats_q.push_back(IN_W'($urandom));
        load_frame(1'b1);
        collect(n, 1, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        int guard = 0;
        // Reset while summing.
        repeat (4) beats_q.push_back(IN_W'($urandom));
        load_frame(1'b1);
        tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_mid_sum: rdy=%0b vld=%0b busy=%0b required 1 0 0", in_ready, out_valid, busy);
        end
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        release_reset();
        // Reset while a result beat is waiting.
        repeat (6) beats_q.push_back(IN_W'($urandom));
        load_frame(1'b1);
        while (out_valid !== 1'b1 && guard < 4 * DEPTH) begin
            tick();
            guard++;
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b1000 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset_mid_drain: rdy=%0b vld=%0b last=%0b busy=%0b data=%0d required 1 0 0 0 0",
                     in_ready, out_valid, out_last, busy, out_data);
        end
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        release_reset();
        repeat (3) beats_q.push_back({8'd2, 8'd1});
        load_frame(1'b1);
        collect(3, 0, 1'b1);
    endtask

    task automatic test_busy_input();
        repeat (8) beats_q.push_back(IN_W'($urandom));
        load_frame(1'b1);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_last  = 1'b0;
        collect(8, 1, 1'b1);
        // Back in LOAD with the beat still presented: it is taken now.
        in_last = 1'b1;
        exp_q.push_back(ref_sum(16'hFFFF));
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        collect(1, 0, 1'b1);
    endtask

    task automatic test_len1();
        beats_q.push_back({8'd9, 8'd7});
        load_frame(1'b1);
        collect(1, 0, 1'b1);
        n_vec++;
        if (first_valid_cyc + 1 - last_acc_cyc != 4 || last_out_cyc - last_acc_cyc != 4) begin
            n_err++;
            $display("FAIL len1_timing: first=%0d last=%0d required 4 4",
                     first_valid_cyc + 1 - last_acc_cyc, last_out_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            int n = $urandom_range(1, DEPTH);
            repeat (n) beats_q.push_back(IN_W'($urandom));
            load_frame((n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)));
            collect(n, 2, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_backpressure();
        test_reset_mid_op();
        test_busy_input();
        test_len1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_accum.md
# mem_accum

Parametrised multi-channel capture-and-accumulate memory. Each frame of up to DEPTH samples is stored per channel in its own block RAM. All channels are then summed address by address into a result RAM. The result frame is streamed out under valid/ready flow control. The block sits between the sample front-end and downstream consumers.

## Interface
Parameters:
- DATA_W, 8, width of one channel sample (unsigned)
- DEPTH, 64, maximum frame length in samples; power of two, ≥2
- CH, 2, number of input channels; ≥2
- ADDR_W, $clog2(DEPTH), derived, not overridden
- SUM_W, DATA_W+$clog2(CH), derived result width

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat; high only in LOAD
- in_data  in  CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- in_last  in  1  final beat of the frame
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the result beat
- out_data  out  SUM_W  sum of all channels at one address
- out_last  out  1  final result beat of the frame
- busy  out  1  high in SUM or DRAIN

## Operation
- FSM states: LOAD, SUM, DRAIN. Reset state is LOAD.
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, write address=0, frame length=0. RAM contents are not cleared.
- LOAD: an accepted beat (in_valid & in_ready) writes channel c's sample to channel RAM c at wr_addr, then wr_addr increments.
- The frame closes on the accepted beat with in_last=1, or on the beat at wr_addr=DEPTH-1, whichever comes first. On close, len=wr_addr+1 (1..DEPTH), wr_addr returns to 0, and the FSM moves to SUM.
- A frame is never empty. in_last on the first beat gives len=1.
- SUM: read address k=0..len-1 is issued to all channel RAMs, one address per cycle. One cycle later, the zero-extended SUM_W-bit sum of the CH outputs is written to the result RAM at address k. After len+1 cycles the FSM moves to DRAIN.
- No overflow is possible, because SUM_W covers CH*(2^DATA_W-1).
- DRAIN: the result RAM is read sequentially from 0 to len-1 into an output register.
- The read address advances only when the output register is empty or is being consumed (out_valid & out_ready).
- out_data, out_valid and out_last are held stable while out_valid & !out_ready.
- out_last is high with address len-1. When that beat is accepted, the FSM returns to LOAD on the next cycle.
- in_valid outside LOAD is ignored: in_ready=0 and no RAM write occurs.
- A reset asserted mid-operation clears immediately, and the next frame starts clean.

## Timing
- Channel and result RAMs have synchronous write and 1-cycle registered read.
- Last input beat accepted at cycle T: SUM occupies T+1..T+len+1, DRAIN is entered at T+len+2, and first out_valid=1 at T+len+3.
- With out_ready held high, one result per cycle, and out_last at T+2*len+2.
- in_ready rises the cycle after the out_last beat is accepted.
- Throughput when not back-pressured: 2*len+3 cycles per frame overhead beyond load.

## Configuration
- MEM_ACCUM_SAT_EN defined: each sum is clamped to 2^DATA_W-1 before the result RAM write, then zero-extended to SUM_W. The port width is unchanged.
- MEM_ACCUM_SAT_EN undefined: the full SUM_W sum is stored, with no clamping logic.

## Structure
- Package mem_accum_pkg holds:
  - the state enum (LOAD, SUM, DRAIN);
  - a sum-width function returning DATA_W+$clog2(CH);
  - the saturation constant helper.
- Sub-module sp_ram, parameterised by width and depth, with synchronous write and registered read.
- Instantiation: CH channel RAMs of DATA_W bits and one result RAM of SUM_W bits.
- The FSM, counters and output register live in mem_accum.

## Test plan
- Full frame, all defaults: 64 beats with ch0=i and ch1=2i, no in_last → frame closes at 64; 64 outputs of value 3i; out_last on the 64th; first out_valid 67 cycles after the last input beat.
- Short frame: 5 beats of ch0=ch1=255, in_last on beat 5 → 5 outputs of 510; with MEM_ACCUM_SAT_EN, 5 outputs of 255.
- Backpressure: out_ready alternating 1/0 during DRAIN → each value held while stalled; all len values delivered in order with no duplicates.
- Reset mid-SUM: rst low for 2 cycles → in_ready=1, out_valid=0, busy=0 asynchronously. The next 3-beat frame (ch0=1, ch1=2) then yields 3,3,3.
- Input during busy: in_valid=1 with in_data=0xFFFF throughout SUM/DRAIN → in_ready=0 and outputs unaffected. Beats are accepted only after return to LOAD.
- len=1 edge: single beat with in_last, ch0=7, ch1=9 → single output 16 with out_last=1; in_ready returns the cycle after acceptance.
